apu_shared_unit_arbiter: RTL
============================

# apu_shared_unit_arbiter

Parametrised successor to the fixed-width APU cluster wrapper. It lets NB_CORES core-side APU request ports share NB_UNITS identical execution units, for example FP div/sqrt instances. Requests are arbitrated round-robin, one issue per cycle. Per-unit tag FIFOs record which core issued each operation, so in-order unit results are routed back to the correct core with backpressure. It sits between the cores' APU master ports and a pool of shared units inside the APU cluster.

## Interface
- NB_CORES, 4, number of core-side request ports (≥1)
- NB_UNITS, 2, number of shared execution units (≥1)
- NARGS, 3, operands per request
- WOP, 6, opcode width
- NDSFLAGS, 15, downstream flag width
- NUSFLAGS, 5, upstream flag width
- DEPTH, 4, per-unit tag FIFO depth = max outstanding ops per unit (power of 2, ≥2)
- clk_i  in  1  single clock; all state updates on its rising edge
- rst_i  in  1  synchronous, active-high reset
- core_req_i  in  [NB_CORES]  request valid
- core_gnt_o  out  [NB_CORES]  request accepted this cycle
- core_operands_i  in  [NB_CORES][NARGS][32]  operands
- core_op_i  in  [NB_CORES][WOP]  opcode
- core_flags_i  in  [NB_CORES][NDSFLAGS]  downstream flags
- core_valid_o  out  [NB_CORES]  result valid
- core_ready_i  in  [NB_CORES]  core accepts result
- core_result_o  out  [NB_CORES][32]  result
- core_flags_o  out  [NB_CORES][NUSFLAGS]  upstream flags
- unit_req_o / unit_gnt_i  out/in  [NB_UNITS]  issue handshake
- unit_operands_o, unit_op_o, unit_flags_o  out  per unit  forwarded request fields
- unit_valid_i / unit_ready_o  in/out  [NB_UNITS]  response handshake
- unit_result_i, unit_flags_i  in  per unit  response fields
- busy_o  out  1  any tag FIFO non-empty

## Operation
- **Issue arbitration.**
  - Round-robin pointer rr_q selects the first requesting core at or after rr_q, in cyclic order. This is the winner.
  - Target unit = lowest-index unit whose tag FIFO is not full. If none exists, no unit_req_o is raised.
  - The winner's fields are driven onto the target unit; unit_req_o[target]=1.
  - core_gnt_o[winner] = unit_gnt_i[target]. All other core_gnt_o are 0.
- **On issue handshake (req & gnt):**
  - Push the winner index into the target unit's FIFO.
  - rr_q ← winner+1 (mod NB_CORES).
  - rr_q is unchanged when there is no handshake, so a stalled winner keeps priority.
- unit_req_o is 0 for every non-target unit. Unused unit field outputs are driven 0.
- **Response routing.**
  - Unit u with unit_valid_i[u] targets core c = head of FIFO u.
  - If several valid units target the same core, the lowest-index unit wins. Losers see unit_ready_o=0.
  - The winner sees unit_ready_o[u] = core_ready_i[c].
  - core_valid_o[c], core_result_o[c] and core_flags_o[c] come from the winning unit. Non-valid cores drive all-zero outputs.
- **Pop:** FIFO u pops on unit_valid_i[u] & unit_ready_o[u].
- **Full FIFO:** the full flag is based on the registered count. A full FIFO is never a target, even if it pops in the same cycle.
- **Simultaneous push and pop on the same FIFO:** the count is unchanged.
- **Valid with empty FIFO:** protocol error. Set unit_ready_o[u]=0, drive nothing to any core, and fire a simulation assertion.
- **Reset (including mid-operation):**
  - rr_q=0, all FIFOs emptied.
  - In-flight unit results are discarded after reset; the units must be reset together with this block.

## Timing
- Issue path is combinational: core_req_i → unit_req_o and unit_gnt_i → core_gnt_o in the same cycle. Unit gnt must not combinationally depend on unit req.
- Response path is combinational: unit_valid_i → core_valid_o and core_ready_i → unit_ready_o. Zero added latency.
- Maximum one issue per cycle. Up to NB_UNITS responses per cycle if the target cores differ.
- Reset values, asserted in the cycle after rst_i is sampled high:
  - all core_gnt_o, core_valid_o, unit_req_o, unit_ready_o = 0
  - all data outputs = 0
  - busy_o = 0
- busy_o is registered from the FIFO counts; it reflects the state after the last edge.

## Structure
- Shared package apu_package holds:
  - NARGS_CPU, WOP_CPU, NDSFLAGS_CPU, NUSFLAGS_CPU defaults
  - a helper function for round-robin next-index calculation
- Sub-module apu_tag_fifo, instantiated NB_UNITS times:
  - parameters DEPTH and WIDTH = $clog2(NB_CORES) (minimum 1)
  - push, pop, head, full and empty signals
  - synchronous active-high reset

## Test plan
- **Single request:** core 2 requests, unit 0 gnt=1 → unit_req_o[0]=1, core_gnt_o[2]=1, FIFO0 holds 2. Unit 0 later returns result 0xDEADBEEF → core_valid_o[2]=1 with that result. busy_o returns to 0.
- **Round-robin fairness:** all 4 cores request continuously with unit gnt always 1 → grant order is 0,1,2,3,0 across consecutive cycles.
- **Unit fill:** NB_UNITS=2, DEPTH=4, no responses → 8 grants, with 4 landing on unit 0 then 4 on unit 1. On the 9th cycle there is no unit_req_o and no grant, and the winner keeps priority.
- **Response collision:** units 0 and 1 are both valid for core 1 → unit 0 is routed and unit_ready_o[1]=0. Unit 1 is delivered the next cycle.
- **Backpressure:** core_ready_i[3]=0 while a result is pending → unit_ready_o stays 0 and the FIFO does not pop. Raising ready delivers the result in the same cycle.
- **Reset mid-flight:** rst_i asserted with 3 outstanding ops → next cycle all FIFOs are empty, busy_o=0, rr_q=0, and all outputs are 0.

Source files
------------

// File: rtl/apu_package.sv
// Shared APU cluster defaults and the round-robin index helper.
package apu_package;

  localparam int NARGS_CPU    = 3;
  localparam int WOP_CPU      = 6;
  localparam int NDSFLAGS_CPU = 15;
  localparam int NUSFLAGS_CPU = 5;

  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/apu_tag_fifo.sv
// Per-unit tag FIFO: remembers which core issued each outstanding operation.
module apu_tag_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = AW + 1;
  localparam logic [CNTW-1:0] FULL_CNT = CNTW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q;
  logic [AW-1:0]    rd_q;
  logic [CNTW-1:0]  cnt_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (cnt_q == FULL_CNT);
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage needs no reset: entries are only read while the FIFO is non-empty.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/apu_shared_unit_arbiter.sv
// Shares NB_UNITS execution units among NB_CORES APU request ports with
// round-robin issue and tag-FIFO based in-order result routing.
module apu_shared_unit_arbiter
  import apu_package::*;
#(
  parameter int NB_CORES = 4,
  parameter int NB_UNITS = 2,
  parameter int NARGS    = NARGS_CPU,
  parameter int WOP      = WOP_CPU,
  parameter int NDSFLAGS = NDSFLAGS_CPU,
  parameter int NUSFLAGS = NUSFLAGS_CPU,
  parameter int DEPTH    = 4
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic [NB_CORES-1:0]                    core_req_i,
  output logic [NB_CORES-1:0]                    core_gnt_o,
  input  logic [NB_CORES-1:0][NARGS-1:0][31:0]   core_operands_i,
  input  logic [NB_CORES-1:0][WOP-1:0]           core_op_i,
  input  logic [NB_CORES-1:0][NDSFLAGS-1:0]      core_flags_i,
  output logic [NB_CORES-1:0]                    core_valid_o,
  input  logic [NB_CORES-1:0]                    core_ready_i,
  output logic [NB_CORES-1:0][31:0]              core_result_o,
  output logic [NB_CORES-1:0][NUSFLAGS-1:0]      core_flags_o,
  output logic [NB_UNITS-1:0]                    unit_req_o,
  input  logic [NB_UNITS-1:0]                    unit_gnt_i,
  output logic [NB_UNITS-1:0][NARGS-1:0][31:0]   unit_operands_o,
  output logic [NB_UNITS-1:0][WOP-1:0]           unit_op_o,
  output logic [NB_UNITS-1:0][NDSFLAGS-1:0]      unit_flags_o,
  input  logic [NB_UNITS-1:0]                    unit_valid_i,
  output logic [NB_UNITS-1:0]                    unit_ready_o,
  input  logic [NB_UNITS-1:0][31:0]              unit_result_i,
  input  logic [NB_UNITS-1:0][NUSFLAGS-1:0]      unit_flags_i,
  output logic                                   busy_o
);

  localparam int CW = (NB_CORES > 1) ? $clog2(NB_CORES) : 1;
  localparam int UW = (NB_UNITS > 1) ? $clog2(NB_UNITS) : 1;

  logic [CW-1:0]                rr_q;
  logic                         win_valid;
  logic [CW-1:0]                win_idx;
  logic [CW-1:0]                cand;
  logic                         tgt_valid;
  logic [UW-1:0]                tgt_idx;
  logic [NB_UNITS-1:0]          fifo_push;
  logic [NB_UNITS-1:0]          fifo_pop;
  logic [NB_UNITS-1:0]          fifo_full;
  logic [NB_UNITS-1:0]          fifo_empty;
  logic [NB_UNITS-1:0][CW-1:0]  fifo_head;
  logic [NB_CORES-1:0]          claimed;

  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NB_CORES; k++) begin
      cand = CW'((int'(rr_q) + k) % NB_CORES);
      if (!win_valid && core_req_i[cand]) begin
        win_valid = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Descending scan leaves the lowest non-full unit as the target.
  always_comb begin
    tgt_valid = 1'b0;
    tgt_idx   = '0;
    for (int u = NB_UNITS - 1; u >= 0; u--) begin
      if (!fifo_full[u]) begin
        tgt_valid = 1'b1;
        tgt_idx   = UW'(u);
      end
    end
  end

  always_comb begin
    unit_req_o      = '0;
    unit_operands_o = '0;
    unit_op_o       = '0;
    unit_flags_o    = '0;
    core_gnt_o      = '0;
    fifo_push       = '0;
    if (win_valid && tgt_valid) begin
      unit_req_o[tgt_idx]      = 1'b1;
      unit_operands_o[tgt_idx] = core_operands_i[win_idx];
      unit_op_o[tgt_idx]       = core_op_i[win_idx];
      unit_flags_o[tgt_idx]    = core_flags_i[win_idx];
      core_gnt_o[win_idx]      = unit_gnt_i[tgt_idx];
      fifo_push[tgt_idx]       = unit_gnt_i[tgt_idx];
    end
  end

  // A stalled winner keeps the pointer, so it stays first in line.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q <= '0;
    end else if (|fifo_push) begin
      rr_q <= CW'(rr_next(int'(win_idx), NB_CORES));
    end
  end

  always_comb begin
    core_valid_o  = '0;
    core_result_o = '0;
    core_flags_o  = '0;
    unit_ready_o  = '0;
    claimed       = '0;
    for (int u = 0; u < NB_UNITS; u++) begin
      if (unit_valid_i[u] && !fifo_empty[u] && !claimed[fifo_head[u]]) begin
        claimed[fifo_head[u]]       = 1'b1;
        core_valid_o[fifo_head[u]]  = 1'b1;
        core_result_o[fifo_head[u]] = unit_result_i[u];
        core_flags_o[fifo_head[u]]  = unit_flags_i[u];
        unit_ready_o[u]             = core_ready_i[fifo_head[u]];
      end
    end
  end

  assign fifo_pop = unit_valid_i & unit_ready_o;
  assign busy_o   = ~&fifo_empty;

  for (genvar u = 0; u < NB_UNITS; u++) begin : g_unit
    apu_tag_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (CW)
    ) u_tag_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (fifo_push[u]),
      .data_i  (win_idx),
      .pop_i   (fifo_pop[u]),
      .head_o  (fifo_head[u]),
      .full_o  (fifo_full[u]),
      .empty_o (fifo_empty[u])
    );

    always_ff @(posedge clk_i) begin
      if (!rst_i) begin
        assert (!(unit_valid_i[u] && fifo_empty[u]))
          else $error("unit %0d returned a result with no outstanding tag", u);
      end
    end
  end

endmodule
